// File: rtl/bias2_train_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : bias2_train_ctrl_if
//  Description : Handshake bundle between the layer-2 bias training sequencer
//                and the datapath / agent controller.
//                  start    - one-cycle request to begin a training run
//                  fwd_done - datapath strobe: forward pass complete
//                  bp_done  - datapath strobe: deltas valid and stable
//                  ctrl     - phase code (0000 idle, 0010 fwd, 0100 bp, 0001 upd)
//                  step     - current iteration 1..NUM_ITER, 0 when idle
//                  busy     - run in progress (FWD/BP/UPD)
//                  done     - one-cycle completion pulse
//                  err      - sticky timeout flag
//                master = sequencer side, slave = datapath/agent side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bias2_train_ctrl_if;
    logic       start;
    logic       fwd_done;
    logic       bp_done;
    logic [3:0] ctrl;
    logic [3:0] step;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        input  start, fwd_done, bp_done,
        output ctrl, step, busy, done, err
    );

    modport slave (
        output start, fwd_done, bp_done,
        input  ctrl, step, busy, done, err
    );
endinterface
`default_nettype wire

// File: rtl/bias2_train_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bias2_train_ctrl
//  Description : Training-loop sequencer for the layer-2 bias bank. Each
//                iteration runs forward pass, backprop and a single-cycle
//                update; a timeout guards the FWD/BP waits.
//  Ports       : clk  - system clock (rising edge)
//                rst  - synchronous active-high reset
//                bus  - bias2_train_ctrl_if.master (start, fwd_done, bp_done
//                       in; ctrl, step, busy, done, err out)
//  Parameters  : NUM_ITER - iterations per run (1..15)
//                TIMEOUT  - max cycles waiting in FWD or BP (2..255)
//  Revision    : 1.0 - initial release
// ============================================================================
module bias2_train_ctrl #(
    parameter int NUM_ITER = 10,
    parameter int TIMEOUT  = 64
) (
    input  logic               clk,
    input  logic               rst,
    bias2_train_ctrl_if.master bus
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_FWD  = 3'd1;
    localparam logic [2:0] S_BP   = 3'd2;
    localparam logic [2:0] S_UPD  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
    localparam logic [2:0] S_ERR  = 3'd5;

    localparam logic [3:0] LAST_ITER = 4'(NUM_ITER);
    localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);

    logic [2:0] state, state_nxt;
    logic [3:0] step_cnt, step_nxt;
    logic [7:0] tmo_cnt, tmo_nxt;

    always_comb begin
        state_nxt = state;
        step_nxt  = step_cnt;
        tmo_nxt   = tmo_cnt;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                tmo_nxt  = 8'd0;
                step_nxt = 4'd0;
                if (bus.start) begin
                    state_nxt = S_FWD;
                    step_nxt  = 4'd1;
                end else if (state == S_DONE) begin
                    state_nxt = S_IDLE;
                end
            end
            S_FWD: begin
                // A strobe on the last allowed cycle still wins over the timeout.
                if (bus.fwd_done) begin
                    state_nxt = S_BP;
                    tmo_nxt   = 8'd0;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_nxt = S_ERR;
                    step_nxt  = 4'd0;
                    tmo_nxt   = 8'd0;
                end else begin
                    tmo_nxt = tmo_cnt + 8'd1;
                end
            end
            S_BP: begin
                if (bus.bp_done) begin
                    state_nxt = S_UPD;
                    tmo_nxt   = 8'd0;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_nxt = S_ERR;
                    step_nxt  = 4'd0;
                    tmo_nxt   = 8'd0;
                end else begin
                    tmo_nxt = tmo_cnt + 8'd1;
                end
            end
            S_UPD: begin
                tmo_nxt = 8'd0;
                if (step_cnt == LAST_ITER) begin
                    state_nxt = S_DONE;
                    step_nxt  = 4'd0;
                end else begin
                    state_nxt = S_FWD;
                    step_nxt  = step_cnt + 4'd1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                step_nxt  = 4'd0;
                tmo_nxt   = 8'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered alongside it,
    // so they change on the same edge as the state with no input-to-output
    // combinational path.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            step_cnt <= 4'd0;
            tmo_cnt  <= 8'd0;
            bus.ctrl <= 4'b0000;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            step_cnt <= step_nxt;
            tmo_cnt  <= tmo_nxt;
            bus.busy <= (state_nxt == S_FWD) || (state_nxt == S_BP) || (state_nxt == S_UPD);
            bus.done <= (state_nxt == S_DONE);
            bus.err  <= (state_nxt == S_ERR);
            case (state_nxt)
                S_FWD:   bus.ctrl <= 4'b0010;
                S_BP:    bus.ctrl <= 4'b0100;
                S_UPD:   bus.ctrl <= 4'b0001;
                default: bus.ctrl <= 4'b0000;
            endcase
        end
    end

    assign bus.step = step_cnt;

endmodule
`default_nettype wire
